// File: rtl/intr_ctrl.sv
// Interrupt controller: IF/IE registers on the MMU strobe bus, priority pick, and IRQ/ack handshake.
// Define INTC_LEVEL_EN for level-sensitive sources; edge-sensitive otherwise. Read data port is dout.
module intr_ctrl #(
  parameter int          NSRC    = 5,
  parameter logic [15:0] IF_ADDR = 16'hFF0F,
  parameter logic [15:0] IE_ADDR = 16'hFFFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] int_req,
  output logic [NSRC-1:0] int_ack,
  input  logic            mem_enable,
  input  logic            rd_n,
  input  logic            wr_n,
  input  logic [15:0]     A,
  input  logic [7:0]      di,
  output logic [7:0]      dout,
  input  logic            ime,
  output logic            cpu_irq,
  output logic [7:0]      cpu_vector,
  input  logic            cpu_int_taken
);

  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic {IDLE, ACK} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx, idx_nxt, win;
  logic [NSRC-1:0] if_q, ie_q, if_nxt, ie_nxt, pend, rise;
  logic [7:0]      rd_val;
  logic            wr_if, wr_ie, rd_en;

  wire unused_di = &{1'b0, di};

`ifdef INTC_LEVEL_EN
  assign rise = int_req;
`else
  logic [NSRC-1:0] req_d;

  // Captures during reset too, so a line already high at release is not an edge.
  always_ff @(posedge clk) req_d <= int_req;

  assign rise = int_req & ~req_d;
`endif

  assign pend  = if_q & ie_q;
  assign rd_en = mem_enable & ~rd_n;
  assign wr_if = mem_enable & ~wr_n & (A == IF_ADDR);
  assign wr_ie = mem_enable & ~wr_n & (A == IE_ADDR);

  always_comb begin
    win = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pend[i]) win = IW'(i);
    end
  end

  always_comb begin
    rd_val = 8'hFF;
    if (A == IF_ADDR)      rd_val = {{(8-NSRC){1'b1}}, if_q};
    else if (A == IE_ADDR) rd_val = {{(8-NSRC){1'b0}}, ie_q};
  end

  // Later assignments win: bus write, then service clear, then new edges.
  always_comb begin
    if_nxt = if_q;
    ie_nxt = ie_q;
    if (wr_if) if_nxt = di[NSRC-1:0];
    if (wr_ie) ie_nxt = di[NSRC-1:0];
    if (state == ACK) if_nxt[idx] = 1'b0;
    if_nxt = if_nxt | rise;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: if (cpu_int_taken && |pend) begin
        state_nxt = ACK;
        idx_nxt   = win;
      end
      ACK:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    int_ack = '0;
    for (int i = 0; i < NSRC; i++) begin
      int_ack[i] = (state == ACK) && (idx == IW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      if_q       <= '0;
      ie_q       <= '0;
      dout       <= 8'h00;
      cpu_irq    <= 1'b0;
      cpu_vector <= 8'h40;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      if_q    <= if_nxt;
      ie_q    <= ie_nxt;
      cpu_irq <= ime & (|pend) & (state == IDLE);
      if (rd_en) dout <= rd_val;
      if (|pend) cpu_vector <= 8'h40 + 8'({win, 3'b000});
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios then random traffic against a reference model.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] int_req = '0;
  logic [4:0] int_ack;
  logic       mem_enable = 1'b0, rd_n = 1'b1, wr_n = 1'b1;
  logic [15:0] A = '0;
  logic [7:0] di = '0;
  logic [7:0] dout;
  logic       ime = 1'b0;
  logic       cpu_irq;
  logic [7:0] cpu_vector;
  logic       cpu_int_taken = 1'b0;

  int errors = 0;
  int checks = 0;

  // Reference model: register contents and a "servicing" flag with the chosen source.
  int m_if = 0, m_ie = 0, m_prev = 0, m_busy = 0, m_idx = 0;
  int m_dout = 0, m_irq = 0, m_vec = 64;

  intr_ctrl dut (
    .clk(clk), .rst(rst), .int_req(int_req), .int_ack(int_ack),
    .mem_enable(mem_enable), .rd_n(rd_n), .wr_n(wr_n), .A(A), .di(di), .dout(dout),
    .ime(ime), .cpu_irq(cpu_irq), .cpu_vector(cpu_vector), .cpu_int_taken(cpu_int_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input int p);
    for (int i = 0; i < 5; i++) if (p[i]) return i;
    return 0;
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare outputs.
  task automatic step();
    int pend, rise, nif;
    @(posedge clk);
    if (rst) begin
      m_if = 0; m_ie = 0; m_dout = 0; m_irq = 0; m_vec = 64; m_busy = 0;
    end else begin
      pend = m_if & m_ie;
`ifdef INTC_LEVEL_EN
      rise = int_req;
`else
      rise = int_req & ~m_prev;
`endif
      if (mem_enable && !rd_n)
        m_dout = (A == 16'hFF0F) ? (8'hE0 | m_if) : (A == 16'hFFFF) ? m_ie : 8'hFF;
      m_irq = (ime && pend != 0 && m_busy == 0) ? 1 : 0;
      if (pend != 0) m_vec = 64 + 8 * lowest(pend);
      nif = m_if;
      if (mem_enable && !wr_n && A == 16'hFF0F) nif = di & 31;
      if (mem_enable && !wr_n && A == 16'hFFFF) m_ie = di & 31;
      if (m_busy != 0) nif = nif & ~(1 << m_idx);
      m_if = nif | rise;
      if (m_busy != 0) m_busy = 0;
      else if (cpu_int_taken && pend != 0) begin
        m_busy = 1;
        m_idx  = lowest(pend);
      end
    end
    m_prev = int_req;
    @(negedge clk);
    chk("int_ack", int_ack, (m_busy != 0) ? (1 << m_idx) : 0);
    chk("cpu_irq", cpu_irq, m_irq);
    chk("cpu_vector", cpu_vector, m_vec);
    chk("dout", dout, m_dout);
    chk("ack_onehot", ($countones(int_ack) <= 1), 1);
  endtask

  task automatic bus_wr(input logic [15:0] addr, input logic [7:0] data);
    mem_enable = 1; wr_n = 0; A = addr; di = data;
    step();
    mem_enable = 0; wr_n = 1;
  endtask

  task automatic bus_rd(input logic [15:0] addr, input logic [7:0] exp, input string tag);
    mem_enable = 1; rd_n = 0; A = addr;
    step();
    chk(tag, dout, exp);
    mem_enable = 0; rd_n = 1;
  endtask

  task automatic service();
    cpu_int_taken = 1;
    step();
    cpu_int_taken = 0;
    step();
  endtask

  initial begin
    // 1: reset
    repeat (3) step();
    rst = 0;
    step();
    chk("rst_irq", cpu_irq, 0);
    chk("rst_ack", int_ack, 0);
    chk("rst_vec", cpu_vector, 8'h40);
    bus_rd(16'hFF0F, 8'hE0, "rst_if");
    bus_rd(16'hFFFF, 8'h00, "rst_ie");

    // 2: single source
    bus_wr(16'hFFFF, 8'h01);
    ime = 1;
    int_req = 5'b00001;
    step();
    int_req = 0;
    bus_rd(16'hFF0F, 8'hE1, "t2_if");
    chk("t2_irq", cpu_irq, 1);
    chk("t2_vec", cpu_vector, 8'h40);
    service();

    // 3: priority between two simultaneous sources
    bus_wr(16'hFFFF, 8'h1F);
    int_req = 5'b00110;
    step();
    int_req = 0;
    step();
    chk("t3_vec", cpu_vector, 8'h48);
    cpu_int_taken = 1;
    step();
    cpu_int_taken = 0;
    chk("t3_ack", int_ack, 5'b00010);
    step();
    chk("t3_ack_end", int_ack, 0);
    bus_rd(16'hFF0F, 8'hE4, "t3_if");
    chk("t3_vec2", cpu_vector, 8'h50);
    service();

    // 4: held request
    int_req = 5'b00001;
    repeat (10) step();
    bus_rd(16'hFF0F, 8'hE1, "t4_if_held");
    service();
    step();
`ifdef INTC_LEVEL_EN
    bus_rd(16'hFF0F, 8'hE1, "t4_if_after");
`else
    bus_rd(16'hFF0F, 8'hE0, "t4_if_after");
`endif
    int_req = 0;
    bus_wr(16'hFF0F, 8'h00);
    step();

    // 5: write 0 racing a new edge
    int_req = 5'b01000;
    bus_wr(16'hFF0F, 8'h00);
    bus_rd(16'hFF0F, 8'hE8, "t5_if");
    int_req = 0;
    bus_wr(16'hFF0F, 8'h00);

    // 6: reset during ACK, then taken with nothing pending
    bus_wr(16'hFFFF, 8'h01);
    int_req = 5'b00001;
    step();
    int_req = 0;
    step();
    cpu_int_taken = 1;
    step();
    cpu_int_taken = 0;
    chk("t6_ack_live", int_ack, 5'b00001);
    rst = 1;
    step();
    chk("t6_ack_rst", int_ack, 0);
    rst = 0;
    step();
    bus_wr(16'hFFFF, 8'h01);
    cpu_int_taken = 1;
    step();
    cpu_int_taken = 0;
    chk("t6_no_ack", int_ack, 0);
    step();
    chk("t6_no_ack2", int_ack, 0);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) int_req = int_req ^ 5'($urandom_range(0, 31));
      ime = ($urandom_range(0, 7) != 0);
      cpu_int_taken = ($urandom_range(0, 3) == 0);
      mem_enable = $urandom_range(0, 1);
      rd_n = $urandom_range(0, 1);
      wr_n = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 2))
        0: A = 16'hFF0F;
        1: A = 16'hFFFF;
        default: A = 16'($urandom);
      endcase
      di = 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
